sensor_frame_tx: RTL and testbench
==================================

// Module: sensor_frame_tx
// PURPOSE
//  Packetiser directly upstream of the UART transmitter: accepts 16-bit sensor samples
//  over a valid/ready handshake and buffers them in a small FIFO. Each sample becomes a
//  5-byte frame, fed one byte at a time to the UART TX start/data/busy/done interface.
//  Frame: [0]=SYNC 8'hA5, [1]={chan[3:0],seq[3:0]}, [2]=data[15:8], [3]=data[7:0],
//  [4]=XOR of bytes 0..3.
// PARAMETERS
//  FIFO_DEPTH  8   sample FIFO entries; power of two, >=2
// PORTS
//  clk           in   1   single clock; all logic on posedge
//  rst           in   1   synchronous, active-high reset
//  enable        in   1   1=start new frames; 0=finish current frame, then hold
//  sample_valid  in   1   sample offered
//  sample_ready  out  1   FIFO can accept (= !full)
//  sample_data   in   16  sensor sample
//  sample_chan   in   4   source channel id
//  tx_start      out  1   1-cycle pulse to UART TX; tx_data valid in the same cycle
//  tx_data       out  8   byte for UART TX
//  tx_busy       in   1   UART TX busy (registered, high the cycle after start)
//  tx_done       in   1   UART TX 1-cycle stop-bit-complete pulse
//  busy          out  1   1 when FSM != IDLE or FIFO non-empty
//  frame_cnt     out  16  frames fully sent; wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset values: sample_ready=0 during rst, 1 the cycle after; tx_start=0, tx_data=0,
//   busy=0, frame_cnt=0, seq=0. FIFO is flushed and FSM=IDLE.
//  Push: on posedge when sample_valid && sample_ready; {chan,data} written.
//   Full: ready=0, no write, nothing dropped.
//  FSM IDLE->LOAD: when enable && !empty.
//  LOAD: pop 1 entry into the frame register; precompute the checksum; byte_idx=0 -> SEND.
//  SEND: if !tx_busy, drive tx_start=1 and tx_data=frame[byte_idx] for exactly 1 cycle -> WAIT.
//   If tx_busy=1, hold in SEND with no pulse. This covers the UART still finishing a byte
//   after our reset.
//  WAIT: hold until tx_done. On tx_done: if byte_idx==4, go to IDLE, frame_cnt++ and seq++.
//   Otherwise byte_idx++ and go to SEND.
//  Never issue tx_start outside SEND. tx_data holds its last value between pulses.
//  Latency: a sample pushed into an empty FIFO at edge N gives tx_start high in cycle N+3,
//   provided tx_busy=0.
//  seq: 4-bit, wraps 15->0. It increments per completed frame, not per pop.
//  Simultaneous push and pop in the LOAD cycle: both take effect; count is unchanged.
//  A pop when full frees a slot; ready rises the next cycle.
//  enable dropped mid-frame: the remaining bytes are still sent; no new LOAD until enable=1.
//  rst mid-frame: the frame is abandoned with no further tx_start; the partial frame is not
//   counted. The downstream receiver resyncs on SYNC.
//  tx_done seen outside WAIT: ignored.
// STRUCTURE
//  sensor_uart_pkg: SYNC_BYTE=8'hA5, FRAME_LEN=5, typedef enum {IDLE,LOAD,SEND,WAIT}
//   frame_state_t.
//  Sub-module sync_fifo #(WIDTH=20, DEPTH=FIFO_DEPTH): ptr+1-bit wrap scheme, full/empty
//   outputs, synchronous rst.
//  Top: FSM, 5x8 frame register, byte_idx[2:0], seq[3:0], frame_cnt. Connect to
//   uart_tx start/data_in/busy/done.
// TESTING
//  1 Push chan=3 data=16'h1234 after reset, stub UART (done 10 cycles after start)
//    -> bytes A5,30,12,34,B3. frame_cnt=1. First tx_start at N+3.
//  2 Push 9 samples back-to-back with a stalled UART, FIFO_DEPTH=8
//    -> ready low after the 8th accept; no sample lost; seq of frames 0..8 = 0..8.
//  3 Send 17 frames -> seq field wraps 15->0 at frame 16. frame_cnt=17.
//  4 enable=0 after byte 2 of frame 1 -> frame 1 completes (5 pulses), then idle with FIFO
//    non-empty. enable=1 resumes.
//  5 Hold tx_busy=1 through SEND -> no tx_start until busy falls. Then exactly 1 pulse.
//  6 rst asserted while in WAIT on byte 3 -> no tx_start after rst; frame_cnt=0;
//    ready=1; next sample framed with seq=0.
//  Full integration: drive uart_tx and uart_rx in loopback -> rx bytes match frames;
//   checksum holds on random data.

Source files
------------

// File: rtl/sensor_uart_pkg.sv
// Shared types and constants for the sensor frame packetiser.
// Frame layout: SYNC, {chan,seq}, data hi, data lo, XOR checksum.
package sensor_uart_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int FRAME_LEN = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT
  } frame_state_t;

  typedef struct packed {
    logic [3:0]  chan;
    logic [15:0] data;
  } sample_t;

  typedef logic [FRAME_LEN-1:0][7:0] frame_t;

  function automatic frame_t build_frame(
    input sample_t    s,
    input logic [3:0] seq
  );
    frame_t f;
    f[0] = SYNC_BYTE;
    f[1] = {s.chan, seq};
    f[2] = s.data[15:8];
    f[3] = s.data[7:0];
    f[4] = f[0] ^ f[1] ^ f[2] ^ f[3];
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, pointer plus wrap bit for full/empty.
// Show-ahead read: rd_data is the head entry whenever !empty.
module sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/sensor_frame_tx.sv
// Sensor sample packetiser: FIFO-buffered samples become 5-byte
// frames handed one byte at a time to a UART transmitter.
module sensor_frame_tx
  import sensor_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [15:0] sample_data,
  input  logic [3:0]  sample_chan,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  frame_state_t state_q, state_d;

  sample_t    head;
  logic       full, empty, push;
  logic       pop, fire, next_byte, finish;
  frame_t     frame;
  logic [2:0] byte_idx;
  logic [3:0] seq;

  assign sample_ready = !full && !rst;
  assign push         = sample_valid && sample_ready;
  assign busy         = (state_q != IDLE) || !empty;

  sync_fifo #(
    .WIDTH($bits(sample_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .wr_data({sample_chan, sample_data}),
    .pop    (pop),
    .rd_data(head),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    fire      = 1'b0;
    next_byte = 1'b0;
    finish    = 1'b0;
    unique case (state_q)
      IDLE: if (enable && !empty) state_d = LOAD;
      LOAD: begin
        pop     = 1'b1;
        state_d = SEND;
      end
      SEND: if (!tx_busy) begin
        fire    = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (tx_done) begin
        if (byte_idx == 3'(FRAME_LEN - 1)) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else begin
          next_byte = 1'b1;
          state_d   = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Start/data are registered so the UART sees a clean one-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      frame     <= '0;
      byte_idx  <= '0;
      seq       <= '0;
      frame_cnt <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
    end else begin
      tx_start <= fire;
      if (fire) tx_data <= frame[byte_idx];
      if (pop) begin
        frame    <= build_frame(head, seq);
        byte_idx <= '0;
      end
      if (next_byte) byte_idx <= byte_idx + 3'd1;
      if (finish) begin
        frame_cnt <= frame_cnt + 16'd1;
        seq       <= seq + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_sensor_frame_tx.sv
// Scoreboard bench for sensor_frame_tx with a stub UART transmitter.
// Expected bytes are queued on push and popped on each tx_start.
module tb_sensor_frame_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [15:0] sample_data = '0;
  logic [3:0]  sample_chan = '0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        tx_done = 1'b0;
  logic        busy;
  logic [15:0] frame_cnt;

  int errs = 0;
  int checks = 0;
  int pulses = 0;
  bit stall = 1'b0;
  bit force_busy = 1'b0;
  logic busy_at_edge = 1'b0;
  logic [3:0] model_seq = '0;
  int model_frames = 0;
  logic [7:0] exp_q[$];
  logic [7:0] seen[$];

  sensor_frame_tx #(.FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sample_data (sample_data),
    .sample_chan (sample_chan),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART stub: busy the cycle after start, done pulse 10 cycles later
  initial begin : uart_stub
    int  cnt;
    bit  act;
    bit  start_seen;
    cnt = 0;
    act = 0;
    start_seen = 0;
    forever begin
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      if (act) begin
        if (!stall) cnt++;
        if (cnt >= 10) begin
          tx_done = 1'b1;
          act = 0;
        end
      end
      if (start_seen) begin
        act = 1;
        cnt = 0;
      end
      start_seen = tx_start;
      tx_busy = act | force_busy;
    end
  end

  always @(posedge clk) busy_at_edge <= tx_busy;

  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && tx_start) begin
        pulses++;
        seen.push_back(tx_data);
        check("start_while_busy", busy_at_edge, 1'b0);
        check("start_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tx_byte", tx_data, e);
        end
      end
    end
  end

  task automatic expect_frame(input logic [3:0] ch, input logic [15:0] d);
    logic [7:0] b[5];
    b[0] = 8'hA5;
    b[1] = {ch, model_seq};
    b[2] = d[15:8];
    b[3] = d[7:0];
    b[4] = b[0] ^ b[1] ^ b[2] ^ b[3];
    for (int i = 0; i < 5; i++) exp_q.push_back(b[i]);
    model_seq++;
    model_frames++;
  endtask

  task automatic push_sample(input logic [3:0] ch, input logic [15:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    sample_valid = 1'b1;
    sample_chan = ch;
    sample_data = d;
    while (!sample_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (!sample_ready) begin
      check("push_timeout", 0, 1);
      sample_valid = 1'b0;
    end else begin
      expect_frame(ch, d);
      @(posedge clk);
      #1 sample_valid = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b0;
    exp_q.delete();
    seen.delete();
    model_seq = '0;
    model_frames = 0;
    #1 check("rst_ready_low", sample_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    pulses = 0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_high", sample_ready, 1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_done", exp_q.size() == 0 && !busy, 1);
    check("frame_cnt", frame_cnt, model_frames);
  endtask

  task automatic wait_pulses(input int n);
    int guard;
    guard = 0;
    while (pulses < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("wait_pulses", pulses >= n, 1);
  endtask

  initial begin : main
    logic [7:0] b;
    apply_reset();

    // Single frame: exact bytes and N+3 latency
    push_sample(4'd3, 16'h1234);
    repeat (2) @(posedge clk);
    #1 check("lat_n2_quiet", tx_start, 0);
    @(posedge clk);
    #1 check("lat_n3_start", tx_start, 1);
    drain();
    check("t1_count", seen.size(), 5);
    b = seen[0]; check("t1_b0", b, 8'hA5);
    b = seen[1]; check("t1_b1", b, 8'h30);
    b = seen[2]; check("t1_b2", b, 8'h12);
    b = seen[3]; check("t1_b3", b, 8'h34);
    b = seen[4]; check("t1_b4", b, 8'hB3);

    // FIFO fill with stalled UART, nothing lost
    apply_reset();
    enable = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 8; i++) push_sample(4'(i), 16'(16'h1000 + i));
    @(negedge clk);
    check("full_ready_low", sample_ready, 0);
    check("full_busy", busy, 1);
    enable = 1'b1;
    push_sample(4'd8, 16'h1008);
    stall = 1'b0;
    drain();

    // Sequence wrap over 17 frames
    apply_reset();
    for (int i = 0; i < 17; i++)
      push_sample(4'(i), 16'($urandom_range(0, 65535)));
    drain();
    b = seen[15 * 5 + 1]; check("seq15", b[3:0], 4'hF);
    b = seen[16 * 5 + 1]; check("seq16_wrap", b[3:0], 4'h0);

    // enable dropped mid-frame
    apply_reset();
    for (int i = 0; i < 3; i++) push_sample(4'hA, 16'(16'hC0DE + i));
    wait_pulses(2);
    enable = 1'b0;
    repeat (100) @(negedge clk);
    check("en_off_pulses", pulses, 5);
    check("en_off_busy", busy, 1);
    check("en_off_cnt", frame_cnt, 1);
    enable = 1'b1;
    drain();
    check("en_on_pulses", pulses, 15);

    // tx_busy held through SEND
    apply_reset();
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    push_sample(4'h7, 16'h55AA);
    repeat (30) @(negedge clk);
    check("busy_hold", pulses, 0);
    force_busy = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_release", pulses, 1);
    drain();

    // Reset while waiting on byte 3
    apply_reset();
    push_sample(4'h2, 16'hFACE);
    wait_pulses(4);
    repeat (3) @(negedge clk);
    apply_reset();
    repeat (20) @(negedge clk);
    check("post_rst_quiet", pulses, 0);
    check("post_rst_cnt", frame_cnt, 0);
    push_sample(4'h5, 16'hBEEF);
    drain();
    b = seen[1]; check("post_rst_seq", b[3:0], 4'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
